// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready buffer for any DEPTH, with an optional output register,
// occupancy level, almost flags, synchronous flush and a sticky overflow flag.
module stream_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int OUTPUT_REG = 0,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2,
   parameter int LW         = $clog2(DEPTH + 2)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_valid,
   output logic                  write_ready,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  read_valid,
   input  logic                  read_ready,
   output logic [LW-1:0]         level,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
   localparam logic [LW-1:0] AF_L   = LW'(AF_THRESH);
   localparam logic [LW-1:0] AE_L   = LW'(AE_THRESH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_mcount;
   logic [LW-1:0]         r_level;
   logic                  r_overflow;

   logic                  w_wr;
   logic                  w_rd;
   logic                  w_mem_rd;
   logic                  w_mem_nz;
   logic [DATA_WIDTH-1:0] w_head;
   logic [CW-1:0]         w_mcount_nxt;
   logic [LW-1:0]         w_level_nxt;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == P_LAST) ? '0 : p + PW'(1);
   endfunction

   assign w_head      = r_mem[r_rd_ptr];
   assign w_mem_nz    = (r_mcount != '0);
   assign write_ready = (r_mcount != C_FULL);
   assign w_wr        = write_valid & write_ready;
   assign w_rd        = read_valid & read_ready;

   generate
      if (OUTPUT_REG != 0) begin : g_oreg
         logic [DATA_WIDTH-1:0] r_oreg;
         logic                  r_ovalid;

         // the head moves into the output register whenever it is empty or being drained
         assign w_mem_rd = w_mem_nz & (~r_ovalid | w_rd);

         // output register stage
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               r_oreg   <= '0;
               r_ovalid <= 1'b0;
            end else if (flush) begin
               r_oreg   <= '0;
               r_ovalid <= 1'b0;
            end else if (w_mem_rd) begin
               r_oreg   <= w_head;
               r_ovalid <= 1'b1;
            end else if (w_rd) begin
               r_ovalid <= 1'b0;
            end
         end

         assign read_valid = r_ovalid;
         assign read_data  = r_ovalid ? r_oreg : '0;
      end else begin : g_direct
         assign w_mem_rd   = w_rd;
         assign read_valid = w_mem_nz;
         assign read_data  = w_mem_nz ? w_head : '0;
      end
   endgenerate

   // next memory count and total level
   always_comb begin
      w_mcount_nxt = r_mcount;
      w_level_nxt  = r_level;
      unique case ({w_wr, w_mem_rd})
         2'b10:   w_mcount_nxt = r_mcount + CW'(1);
         2'b01:   w_mcount_nxt = r_mcount - CW'(1);
         default: w_mcount_nxt = r_mcount;
      endcase
      unique case ({w_wr, w_rd})
         2'b10:   w_level_nxt = r_level + LW'(1);
         2'b01:   w_level_nxt = r_level - LW'(1);
         default: w_level_nxt = r_level;
      endcase
   end

   // pointers, counts and sticky overflow; flush beats any transfer
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_mcount   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else if (flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_mcount   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr)
            r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_mem_rd)
            r_rd_ptr <= next_ptr(r_rd_ptr);
         r_mcount <= w_mcount_nxt;
         r_level  <= w_level_nxt;
         if (write_valid & ~write_ready)
            r_overflow <= 1'b1;
      end
   end

   // storage array, deliberately not reset
   always_ff @(posedge clock) begin
      if (w_wr & ~flush)
         r_mem[r_wr_ptr] <= write_data;
   end

   assign level        = r_level;
   assign almost_full  = (r_level >= AF_L);
   assign almost_empty = (r_level <= AE_L);
   assign overflow     = r_overflow;

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: three stream_fifo variants driven by common stimulus,
// each tracked by its own scoreboard queue and occupancy model.
module tb_stream_fifo;

   logic        clock;
   logic        reset;
   logic        fl;
   logic [31:0] wd;
   logic        wv;
   logic        rr;
   logic        run;

   logic [31:0] rd  [3];
   logic        rv  [3];
   logic        wr  [3];
   logic        af  [3];
   logic        ae  [3];
   logic        ovf [3];
   logic [4:0]  lv0;
   logic [2:0]  lv1;
   logic [4:0]  lv2;
   int          lv  [3];

   int          n_vec;
   int          n_err;
   logic [31:0] sb    [3][$];
   int          m_lvl [3];
   logic        m_ovf [3];
   int          nrd   [3];
   int          nwr   [3];
   int          depth [3];
   int          s0;
   int          s1;
   int          s2;
   logic [31:0] dcnt;

   stream_fifo #(.DATA_WIDTH(32), .DEPTH(16), .OUTPUT_REG(0)) u0 (
      .clock(clock), .reset(reset), .flush(fl),
      .write_data(wd), .write_valid(wv), .write_ready(wr[0]),
      .read_data(rd[0]), .read_valid(rv[0]), .read_ready(rr),
      .level(lv0), .almost_full(af[0]), .almost_empty(ae[0]),
      .overflow(ovf[0]));

   stream_fifo #(.DATA_WIDTH(32), .DEPTH(5), .OUTPUT_REG(0)) u1 (
      .clock(clock), .reset(reset), .flush(fl),
      .write_data(wd), .write_valid(wv), .write_ready(wr[1]),
      .read_data(rd[1]), .read_valid(rv[1]), .read_ready(rr),
      .level(lv1), .almost_full(af[1]), .almost_empty(ae[1]),
      .overflow(ovf[1]));

   stream_fifo #(.DATA_WIDTH(32), .DEPTH(16), .OUTPUT_REG(1)) u2 (
      .clock(clock), .reset(reset), .flush(fl),
      .write_data(wd), .write_valid(wv), .write_ready(wr[2]),
      .read_data(rd[2]), .read_valid(rv[2]), .read_ready(rr),
      .level(lv2), .almost_full(af[2]), .almost_empty(ae[2]),
      .overflow(ovf[2]));

   always_comb begin
      lv[0] = int'(lv0);
      lv[1] = int'(lv1);
      lv[2] = int'(lv2);
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d,
                        input logic r, input logic f);
      wv = v;
      wd = d;
      rr = r;
      fl = f;
      @(posedge clock);
      #1;
   endtask

   task automatic clear_models();
      for (int k = 0; k < 3; k++) begin
         sb[k].delete();
         m_lvl[k] = 0;
         m_ovf[k] = 1'b0;
      end
   endtask

   task automatic check_idle(input string tag);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s_wr%0d", tag, k), 64'(wr[k]), 64'd1);
         check($sformatf("%s_rv%0d", tag, k), 64'(rv[k]), 64'd0);
         check($sformatf("%s_rd%0d", tag, k), 64'(rd[k]), 64'd0);
         check($sformatf("%s_lv%0d", tag, k), 64'(lv[k]), 64'd0);
         check($sformatf("%s_ae%0d", tag, k), 64'(ae[k]), 64'd1);
         check($sformatf("%s_af%0d", tag, k), 64'(af[k]), 64'd0);
         check($sformatf("%s_ov%0d", tag, k), 64'(ovf[k]), 64'd0);
      end
   endtask

   // per-cycle scoreboard: check outputs, then apply the upcoming edge
   always @(negedge clock) begin
      if (run && !reset) begin
         for (int k = 0; k < 3; k++) begin
            logic ew;
            logic w;
            logic r;
            if (k == 2)
               ew = ((m_lvl[k] - (rv[k] ? 1 : 0)) != depth[k]);
            else
               ew = (m_lvl[k] != depth[k]);
            check($sformatf("wrdy%0d", k), 64'(wr[k]), 64'(ew));
            if (k == 2) begin
               if (m_lvl[k] == 0)
                  check("rv2_empty", 64'(rv[k]), 64'd0);
               else if (m_lvl[k] >= 2)
                  check("rv2_busy", 64'(rv[k]), 64'd1);
            end else begin
               check($sformatf("rv%0d", k), 64'(rv[k]), 64'(m_lvl[k] != 0));
            end
            if (rv[k]) begin
               if (sb[k].size() == 0)
                  check($sformatf("sbempty%0d", k), 64'd1, 64'd0);
               else
                  check($sformatf("data%0d", k), 64'(rd[k]), 64'(sb[k][0]));
            end else begin
               check($sformatf("rdzero%0d", k), 64'(rd[k]), 64'd0);
            end
            check($sformatf("lvl%0d", k), 64'(lv[k]), 64'(m_lvl[k]));
            check($sformatf("af%0d", k), 64'(af[k]),
                  64'(m_lvl[k] >= depth[k] - 2));
            check($sformatf("ae%0d", k), 64'(ae[k]), 64'(m_lvl[k] <= 2));
            check($sformatf("ovf%0d", k), 64'(ovf[k]), 64'(m_ovf[k]));
            w = wv & wr[k];
            r = rv[k] & rr;
            if (fl) begin
               sb[k].delete();
               m_lvl[k] = 0;
               m_ovf[k] = 1'b0;
            end else begin
               if (r && sb[k].size() > 0)
                  void'(sb[k].pop_front());
               if (w)
                  sb[k].push_back(wd);
               m_lvl[k] = m_lvl[k] + (w ? 1 : 0) - (r ? 1 : 0);
               if (wv && !wr[k])
                  m_ovf[k] = 1'b1;
               nrd[k] = nrd[k] + (r ? 1 : 0);
               nwr[k] = nwr[k] + (w ? 1 : 0);
            end
         end
      end
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      run   = 1'b0;
      depth = '{16, 5, 16};
      nrd   = '{0, 0, 0};
      nwr   = '{0, 0, 0};
      clear_models();
      wv    = 1'b0;
      wd    = '0;
      rr    = 1'b0;
      fl    = 1'b0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #2 check_idle("rst");
      @(posedge clock);
      #1 reset = 1'b0;
      run = 1'b1;

      // fill past full, then drain in order
      dcnt = 32'h100;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, dcnt, 1'b0, 1'b0);
         dcnt++;
      end
      check("full_lv0", 64'(lv[0]), 64'd16);
      check("full_lv1", 64'(lv[1]), 64'd5);
      check("full_lv2", 64'(lv[2]), 64'd17);
      check("full_ov0", 64'(ovf[0]), 64'd1);
      for (int i = 0; i < 20; i++)
         drive(1'b0, 32'h0, 1'b1, 1'b0);
      check("drain_ov0", 64'(ovf[0]), 64'd1);

      // flush with a simultaneous write
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, dcnt, 1'b0, 1'b0);
         dcnt++;
      end
      drive(1'b1, 32'hDEAD, 1'b1, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check_idle("flush");

      // single write latency
      drive(1'b1, 32'hA5, 1'b0, 1'b0);
      wv = 1'b0;
      @(negedge clock);
      check("lat_u0", 64'(rv[0]), 64'd1);
      check("lat_u2a", 64'(rv[2]), 64'd0);
      @(posedge clock);
      #1;
      @(negedge clock);
      check("lat_u2b", 64'(rv[2]), 64'd1);
      check("lat_d2", 64'(rd[2]), 64'hA5);
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++)
         drive(1'b0, 32'h0, 1'b1, 1'b0);

      // random interleave; DEPTH=5 sweeps empty..full
      for (int i = 0; i < 200; i++) begin
         drive(1'($urandom_range(0, 1)), dcnt, 1'($urandom_range(0, 1)), 1'b0);
         dcnt++;
      end
      for (int i = 0; i < 25; i++)
         drive(1'b0, 32'h0, 1'b1, 1'b0);

      // steady state at level 8
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, dcnt, 1'b0, 1'b0);
         dcnt++;
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, dcnt, 1'b1, 1'b0);
         dcnt++;
      end
      check("l8_u0", 64'(lv[0]), 64'd8);
      check("l8_u2", 64'(lv[2]), 64'd8);
      for (int i = 0; i < 25; i++)
         drive(1'b0, 32'h0, 1'b1, 1'b0);

      // sustained throughput
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, dcnt, 1'b0, 1'b0);
         dcnt++;
      end
      s0 = nrd[2];
      s1 = nwr[2];
      s2 = nrd[0];
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, dcnt, 1'b1, 1'b0);
         dcnt++;
      end
      check("tput_rd2", 64'(nrd[2] - s0), 64'd100);
      check("tput_wr2", 64'(nwr[2] - s1), 64'd100);
      check("tput_rd0", 64'(nrd[0] - s2), 64'd100);
      for (int i = 0; i < 25; i++)
         drive(1'b0, 32'h0, 1'b1, 1'b0);

      // async reset mid-stream at level 7
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, dcnt, 1'b0, 1'b0);
         dcnt++;
      end
      check("pre_rst", 64'(lv[0]), 64'd7);
      #1 reset = 1'b1;
      #1 check_idle("arst");
      clear_models();
      #1 reset = 1'b0;
      s0 = nrd[0];
      drive(1'b1, 32'h5A5A, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         drive(1'b0, 32'h0, 1'b1, 1'b0);
      check("post_rd0", 64'(nrd[0] - s0), 64'd1);

      for (int k = 0; k < 3; k++)
         check($sformatf("left%0d", k), 64'(sb[k].size()), 64'd0);

      run = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Parametrised synchronous FIFO: next-generation data buffer for accelerator datapaths.
- Adds to the basic buffer: any DEPTH (not only powers of two), an optional registered output stage, an exported occupancy level, programmable almost-full/almost-empty flags, a synchronous flush, and a sticky overflow flag.
- Sits between producer/consumer stages with valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- DEPTH, 16, memory entries; any integer >= 2.
- OUTPUT_REG, 0, 0 = read_data driven from memory head; 1 = extra output register stage.
- AF_THRESH, DEPTH-2, almost_full asserted when level >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserted when level <= AE_THRESH.
- LW (derived), $clog2(DEPTH+2), width of level.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all contents.
- write_data  input  DATA_WIDTH  payload in.
- write_valid  input  1  producer has data.
- write_ready  output  1  FIFO can accept.
- read_data  output  DATA_WIDTH  head payload.
- read_valid  output  1  head valid.
- read_ready  input  1  consumer accepts.
- level  output  LW  entries held (memory + output register).
- almost_full  output  1  level >= AF_THRESH.
- almost_empty  output  1  level <= AE_THRESH.
- overflow  output  1  sticky: write_valid seen while write_ready=0.

Behaviour:
- Reset is asynchronous, active-high.
  - Pointers, level, output register and overflow go to 0.
  - After reset: write_ready=1, read_valid=0, read_data=0, almost_empty=1, almost_full=0.
  - Memory array is not reset.
- Handshakes:
  - Write transfer = write_valid & write_ready at the clock edge.
  - Read transfer = read_valid & read_ready at the clock edge.
  - write_ready depends only on state, never on write_valid.
- Pointers advance modulo DEPTH: explicit compare to DEPTH-1, then wrap to 0, so non-power-of-2 depths work.
- Memory count mcount ranges 0..DEPTH.
  - Write only: +1. Read from memory only: -1.
  - Simultaneous write and memory read: unchanged.
  - Simultaneous write and read at mcount=0 is impossible in OUTPUT_REG=0, because read_valid=0.
- OUTPUT_REG=0:
  - read_valid = (mcount != 0).
  - read_data = memory[rd_ptr] when read_valid, else 0.
  - Write-to-read_valid latency: 1 edge.
  - write_ready = (mcount != DEPTH).
  - level = mcount.
- OUTPUT_REG=1:
  - Output register (oreg, ovalid) loads from the memory head whenever mcount != 0 and (!ovalid or read transfer). The memory read pointer advances on that load.
  - read_valid = ovalid; read_data = oreg when ovalid, else 0.
  - Write-to-read_valid latency: 2 edges.
  - Capacity is DEPTH+1; write_ready = (mcount != DEPTH).
  - level = mcount + ovalid.
  - Sustained one transfer per cycle on both sides with no bubbles.
- Flags:
  - almost_full and almost_empty are combinational from the registered level; no extra latency.
  - Thresholds are compared against level, range 0..DEPTH+OUTPUT_REG.
- Flush (synchronous):
  - At the edge with flush=1: pointers, mcount and ovalid are cleared.
  - Any simultaneous write or read transfer is discarded; flush has priority.
  - overflow is cleared.
  - The next cycle looks like post-reset.
- Overflow:
  - Set at any edge where write_valid=1 and write_ready=0, flush=0.
  - Held until flush or reset. The data is not written.
- Reset asserted mid-operation: immediate async clear; all contents lost.
- Read when empty: no effect. Read and write at full (OUTPUT_REG=0): the write succeeds only if write_ready was 1 at that edge, so no write occurs at full even with a simultaneous read.

Test Plan:
- Fill/drain, DEPTH=16, OUTPUT_REG=0:
  - Write 0x100..0x10F back-to-back -> write_ready drops after the 16th write; level=16; almost_full from level 14.
  - Drain -> data emerges in order; almost_empty once level <= 2; read_data=0 when empty.
- Non-power-of-2 wrap, DEPTH=5:
  - 13 interleaved writes/reads with occupancy 0..5 -> all data in order, no duplication; level matches the model every cycle.
- OUTPUT_REG=1 latency and throughput:
  - Single write of 0xA5 at edge N -> read_valid first high after edge N+1; maximum level=17 with DEPTH=16.
  - 100 cycles of continuous valid/ready on both sides -> 100 transfers, zero bubbles.
- Simultaneous write+read at level 8 -> level stays 8; ordering preserved.
- Overflow and flush:
  - Fill, hold write_valid 3 more cycles -> overflow=1, contents unchanged.
  - flush with a simultaneous write -> next cycle level=0, overflow=0, read_valid=0; the flushed write is absent.
- Async reset mid-stream at level 7 -> all outputs at reset values without a clock edge; a subsequent write is read back correctly.
